// File: rtl/tft_frame_sequencer.sv
// tft_frame_sequencer: frame-level pacing between the pixel reader and the
// TFT command/data writer. Opens each frame with a memory-write command,
// paces pixel strobes, counts column/row against latched dimensions, and
// falls back to a fill colour when the pixel source starves for too long.
module tft_frame_sequencer #(
  parameter int         STALL_LIMIT   = 1024,
  parameter logic [7:0] CMD_MEM_WRITE = 8'h2C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [15:0] i_width,
  input  logic [15:0] i_height,
  input  logic [23:0] i_fill_color,
  input  logic        i_pixel_rdy,
  output logic        o_pixel_stb,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  input  logic        i_tft_rdy,
  output logic        o_cmd_stb,
  output logic [7:0]  o_cmd_data,
  output logic        o_data_stb,
  output logic [23:0] o_data,
  output logic        o_frame_busy,
  output logic        o_frame_done,
  output logic [31:0] o_frame_count,
  output logic        o_underrun,
  output logic        o_cfg_err
);

  localparam int                 STALL_W    = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [STALL_W-1:0] STALL_FULL = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOF   = 2'd1,
    ST_PIXEL = 2'd2,
    ST_EOF   = 2'd3
  } state_t;

  state_t             state_r,  state_nx_s;
  logic [15:0]        width_r,  width_nx_s;
  logic [15:0]        height_r, height_nx_s;
  logic [15:0]        x_r,      x_nx_s;
  logic [15:0]        y_r,      y_nx_s;
  logic [STALL_W-1:0] stall_r,  stall_nx_s;
  logic               fill_r,   fill_nx_s;
  logic               strobe_s;

  logic        pixel_stb_nx_s, cmd_stb_nx_s, data_stb_nx_s;
  logic [7:0]  cmd_data_nx_s;
  logic [23:0] data_nx_s;
  logic        busy_nx_s, done_nx_s, underrun_nx_s, cfg_err_nx_s;
  logic [31:0] count_nx_s;

  // Next-state, counter and registered-output computation for the frame FSM.
  always_comb begin
    state_nx_s     = state_r;
    width_nx_s     = width_r;
    height_nx_s    = height_r;
    x_nx_s         = x_r;
    y_nx_s         = y_r;
    stall_nx_s     = stall_r;
    fill_nx_s      = fill_r;
    strobe_s       = 1'b0;
    pixel_stb_nx_s = 1'b0;
    cmd_stb_nx_s   = 1'b0;
    data_stb_nx_s  = 1'b0;
    cmd_data_nx_s  = o_cmd_data;
    data_nx_s      = o_data;
    busy_nx_s      = o_frame_busy;
    done_nx_s      = 1'b0;
    count_nx_s     = o_frame_count;
    underrun_nx_s  = o_underrun;
    cfg_err_nx_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          if ((i_width != 16'd0) && (i_height != 16'd0)) begin
            width_nx_s    = i_width;
            height_nx_s   = i_height;
            x_nx_s        = 16'd0;
            y_nx_s        = 16'd0;
            stall_nx_s    = '0;
            fill_nx_s     = 1'b0;
            underrun_nx_s = 1'b0;
            busy_nx_s     = 1'b1;
            state_nx_s    = ST_SOF;
          end else begin
            cfg_err_nx_s = 1'b1;
          end
        end else begin
          cfg_err_nx_s = 1'b0;
        end
      end

      ST_SOF: begin
        if (i_tft_rdy) begin
          cmd_stb_nx_s  = 1'b1;
          cmd_data_nx_s = CMD_MEM_WRITE;
          state_nx_s    = ST_PIXEL;
        end else begin
          cmd_stb_nx_s = 1'b0;
        end
      end

      ST_PIXEL: begin
        if (fill_r) begin
          // Fill mode: the reader is bypassed, only the writer paces us.
          if (i_tft_rdy && !o_data_stb) begin
            data_stb_nx_s = 1'b1;
            data_nx_s     = i_fill_color;
            strobe_s      = 1'b1;
          end else begin
            strobe_s = 1'b0;
          end
        end else begin
          // The reader needs a cycle to re-present ready, so never strobe twice in a row.
          if (i_pixel_rdy && i_tft_rdy && !o_pixel_stb) begin
            pixel_stb_nx_s = 1'b1;
            data_stb_nx_s  = 1'b1;
            data_nx_s      = {i_red, i_green, i_blue};
            strobe_s       = 1'b1;
          end else begin
            strobe_s = 1'b0;
          end
          // Starvation watchdog: a strobe proves the source is alive.
          if (o_data_stb) begin
            stall_nx_s = '0;
          end else if (!i_pixel_rdy) begin
            if (stall_r == STALL_LAST) begin
              stall_nx_s    = STALL_FULL;
              fill_nx_s     = 1'b1;
              underrun_nx_s = 1'b1;
            end else begin
              stall_nx_s = stall_r + STALL_ONE;
            end
          end else begin
            stall_nx_s = stall_r;
          end
        end

        // Raster position advances once per data strobe issued.
        if (strobe_s) begin
          if (x_r == (width_r - 16'd1)) begin
            x_nx_s = 16'd0;
            if (y_r == (height_r - 16'd1)) begin
              state_nx_s = ST_EOF;
            end else begin
              y_nx_s = y_r + 16'd1;
            end
          end else begin
            x_nx_s = x_r + 16'd1;
          end
        end else begin
          x_nx_s = x_r;
        end
      end

      ST_EOF: begin
        done_nx_s  = 1'b1;
        count_nx_s = o_frame_count + 32'd1;
        busy_nx_s  = 1'b0;
        state_nx_s = ST_IDLE;
      end

      default: begin
        state_nx_s = ST_IDLE;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs registered; async reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      width_r       <= 16'd0;
      height_r      <= 16'd0;
      x_r           <= 16'd0;
      y_r           <= 16'd0;
      stall_r       <= '0;
      fill_r        <= 1'b0;
      o_pixel_stb   <= 1'b0;
      o_cmd_stb     <= 1'b0;
      o_cmd_data    <= 8'd0;
      o_data_stb    <= 1'b0;
      o_data        <= 24'd0;
      o_frame_busy  <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_count <= 32'd0;
      o_underrun    <= 1'b0;
      o_cfg_err     <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      width_r       <= width_nx_s;
      height_r      <= height_nx_s;
      x_r           <= x_nx_s;
      y_r           <= y_nx_s;
      stall_r       <= stall_nx_s;
      fill_r        <= fill_nx_s;
      o_pixel_stb   <= pixel_stb_nx_s;
      o_cmd_stb     <= cmd_stb_nx_s;
      o_cmd_data    <= cmd_data_nx_s;
      o_data_stb    <= data_stb_nx_s;
      o_data        <= data_nx_s;
      o_frame_busy  <= busy_nx_s;
      o_frame_done  <= done_nx_s;
      o_frame_count <= count_nx_s;
      o_underrun    <= underrun_nx_s;
      o_cfg_err     <= cfg_err_nx_s;
    end
  end

endmodule

// File: tb/tb_tft_frame_sequencer.sv
// tb_tft_frame_sequencer: scenario tasks drive frames through the sequencer;
// pixel values are queued as expected data when presented to the DUT and
// compared in order against the data words the DUT emits.
module tb_tft_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [15:0] i_width, i_height;
  logic [23:0] i_fill_color;
  logic        i_pixel_rdy;
  logic        o_pixel_stb;
  logic [7:0]  i_red, i_green, i_blue;
  logic        i_tft_rdy;
  logic        o_cmd_stb;
  logic [7:0]  o_cmd_data;
  logic        o_data_stb;
  logic [23:0] o_data;
  logic        o_frame_busy, o_frame_done;
  logic [31:0] o_frame_count;
  logic        o_underrun, o_cfg_err;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_frames = 0;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];

  // Per-frame observations gathered by run_frame.
  int          cyc, n_cmd, n_data, n_pix, n_done, bad_rdy, unpaired;
  int          min_gap, max_gap, first_stb, underrun_cyc;
  logic [7:0]  last_cmd;
  logic [31:0] done_cnt;
  logic        ur_at_busy, seen_busy;

  tft_frame_sequencer #(.STALL_LIMIT(8), .CMD_MEM_WRITE(8'h2C)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_width(i_width), .i_height(i_height),
    .i_fill_color(i_fill_color), .i_pixel_rdy(i_pixel_rdy), .o_pixel_stb(o_pixel_stb),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue), .i_tft_rdy(i_tft_rdy),
    .o_cmd_stb(o_cmd_stb), .o_cmd_data(o_cmd_data), .o_data_stb(o_data_stb), .o_data(o_data),
    .o_frame_busy(o_frame_busy), .o_frame_done(o_frame_done), .o_frame_count(o_frame_count),
    .o_underrun(o_underrun), .o_cfg_err(o_cfg_err)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one fresh random pixel and queue it as expected output.
  task automatic present_pixel();
    logic [23:0] px;
    px = 24'($urandom);
    {i_red, i_green, i_blue} = px;
    exp_q.push_back(px);
    i_pixel_rdy = 1'b1;
  endtask

  // Runs until frame_done or max_cycles; reader supplies n_supply pixels.
  // Enable (and width, to 9) is dropped once drop_at data strobes were seen.
  task automatic run_frame(input int n_supply, input int max_cycles, input bit toggle, input int drop_at);
    int k;
    int last_stb;
    exp_q.delete(); obs_q.delete();
    cyc = 0; n_cmd = 0; n_data = 0; n_pix = 0; n_done = 0; bad_rdy = 0; unpaired = 0;
    min_gap = 1000; max_gap = 0; first_stb = -1; underrun_cyc = -1; last_stb = -1;
    last_cmd = 8'd0; done_cnt = 32'hFFFF_FFFF; ur_at_busy = 1'b1; seen_busy = 1'b0;
    k = 0;
    if (n_supply > 0) present_pixel();
    else i_pixel_rdy = 1'b0;
    while (cyc < max_cycles && n_done == 0) begin
      tick();
      cyc++;
      if (o_frame_busy && !seen_busy) begin
        seen_busy  = 1'b1;
        ur_at_busy = o_underrun;
      end
      if (o_cmd_stb) begin
        n_cmd++;
        last_cmd = o_cmd_data;
      end
      if (o_underrun && underrun_cyc < 0) underrun_cyc = cyc;
      if (o_data_stb) begin
        obs_q.push_back(o_data);
        n_data++;
        if (!i_tft_rdy) bad_rdy++;
        if (last_stb >= 0) begin
          if (cyc - last_stb < min_gap) min_gap = cyc - last_stb;
          if (cyc - last_stb > max_gap) max_gap = cyc - last_stb;
        end
        if (first_stb < 0) first_stb = cyc;
        last_stb = cyc;
      end
      if (o_pixel_stb) begin
        n_pix++;
        k++;
        if (!o_data_stb) unpaired++;
        if (k < n_supply) present_pixel();
        else i_pixel_rdy = 1'b0;
      end
      if (o_frame_done) begin
        n_done++;
        done_cnt = o_frame_count;
      end
      if (drop_at >= 0 && n_data == drop_at) begin
        i_enable = 1'b0;
        i_width  = 16'd9;
      end
      if (toggle) i_tft_rdy = ~i_tft_rdy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({o_cmd_stb, o_data_stb, o_pixel_stb, o_frame_busy, o_frame_done, o_underrun, o_cfg_err} !== 7'd0) begin n_bad++; $display("FAIL reset_flags: got %b expected 0", {o_cmd_stb, o_data_stb, o_pixel_stb, o_frame_busy, o_frame_done, o_underrun, o_cfg_err}); end
    n_cmp++; if (o_frame_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", o_frame_count); end
    n_cmp++; if ({o_data, o_cmd_data} !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", {o_data, o_cmd_data}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    i_width = 16'd4; i_height = 16'd2; i_tft_rdy = 1'b1; i_enable = 1'b1;
    run_frame(8, 200, 1'b0, 0);
    exp_frames++;
    n_cmp++; if (n_cmd !== 1) begin n_bad++; $display("FAIL basic_cmd_count: got %0d expected 1", n_cmd); end
    n_cmp++; if (last_cmd !== 8'h2C) begin n_bad++; $display("FAIL basic_cmd_byte: got %h expected 2c", last_cmd); end
    n_cmp++; if (n_data !== 8 || n_pix !== 8 || unpaired !== 0) begin n_bad++; $display("FAIL basic_strobes: got data=%0d pix=%0d unpaired=%0d expected 8/8/0", n_data, n_pix, unpaired); end
    n_cmp++; if (min_gap !== 2 || max_gap !== 2) begin n_bad++; $display("FAIL basic_spacing: got min=%0d max=%0d expected 2/2", min_gap, max_gap); end
    n_cmp++; if (n_done !== 1 || done_cnt !== 32'(exp_frames)) begin n_bad++; $display("FAIL basic_done: got done=%0d count=%0d expected 1/%0d", n_done, done_cnt, exp_frames); end
    n_cmp++; if (o_frame_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b expected 0", o_frame_busy); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_sb_size: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_data[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    i_width = 16'd2; i_height = 16'd1; i_tft_rdy = 1'b1; i_enable = 1'b1;
    run_frame(2, 100, 1'b0, -1);
    exp_frames++;
    n_cmp++; if (n_done !== 1 || done_cnt !== 32'(exp_frames)) begin n_bad++; $display("FAIL b2b_done1: got done=%0d count=%0d expected 1/%0d", n_done, done_cnt, exp_frames); end
    tick();
    n_cmp++; if (o_cmd_stb !== 1'b0) begin n_bad++; $display("FAIL b2b_cmd_early: got %b expected 0", o_cmd_stb); end
    tick();
    n_cmp++; if (o_cmd_stb !== 1'b1) begin n_bad++; $display("FAIL b2b_cmd_at_2: got %b expected 1", o_cmd_stb); end
    run_frame(2, 100, 1'b0, 0);
    exp_frames++;
    n_cmp++; if (n_data !== 2 || n_done !== 1 || done_cnt !== 32'(exp_frames)) begin n_bad++; $display("FAIL b2b_frame2: got data=%0d done=%0d count=%0d expected 2/1/%0d", n_data, n_done, done_cnt, exp_frames); end
  endtask

  task automatic test_tft_toggle();
    i_width = 16'd3; i_height = 16'd1; i_tft_rdy = 1'b1; i_enable = 1'b1;
    run_frame(3, 200, 1'b1, 0);
    i_tft_rdy = 1'b1;
    exp_frames++;
    n_cmp++; if (bad_rdy !== 0) begin n_bad++; $display("FAIL toggle_rdy_violations: got %0d expected 0", bad_rdy); end
    n_cmp++; if (n_data !== 3 || n_done !== 1) begin n_bad++; $display("FAIL toggle_counts: got data=%0d done=%0d expected 3/1", n_data, n_done); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL toggle_sb_size: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL toggle_data[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    i_width = 16'd4; i_height = 16'd1; i_tft_rdy = 1'b1; i_enable = 1'b1;
    i_fill_color = 24'h123456;
    run_frame(1, 300, 1'b0, 0);
    exp_frames++;
    repeat (3) exp_q.push_back(24'h123456);
    n_cmp++; if (n_pix !== 1 || n_data !== 4) begin n_bad++; $display("FAIL stall_strobes: got pix=%0d data=%0d expected 1/4", n_pix, n_data); end
    n_cmp++; if (first_stb < 0 || underrun_cyc - first_stb !== 9) begin n_bad++; $display("FAIL stall_underrun_delay: got %0d expected 9", underrun_cyc - first_stb); end
    n_cmp++; if (n_done !== 1 || o_underrun !== 1'b1) begin n_bad++; $display("FAIL stall_done_sticky: got done=%0d underrun=%b expected 1/1", n_done, o_underrun); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL stall_sb_size: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_data[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    i_width = 16'd1; i_height = 16'd1; i_enable = 1'b1;
    run_frame(1, 100, 1'b0, 0);
    exp_frames++;
    n_cmp++; if (seen_busy !== 1'b1 || ur_at_busy !== 1'b0 || o_underrun !== 1'b0) begin n_bad++; $display("FAIL stall_underrun_clear: got busy_seen=%b underrun_at_sof=%b now=%b expected 1/0/0", seen_busy, ur_at_busy, o_underrun); end
  endtask

  task automatic test_cfg_err();
    int cmds;
    cmds = 0;
    i_width = 16'd0; i_height = 16'd2; i_tft_rdy = 1'b1; i_enable = 1'b1;
    repeat (4) begin
      tick();
      if (o_cmd_stb) cmds++;
    end
    n_cmp++; if (cmds !== 0) begin n_bad++; $display("FAIL cfg_no_cmd: got %0d expected 0", cmds); end
    n_cmp++; if (o_cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err_set: got %b expected 1", o_cfg_err); end
    i_width = 16'd2;
    run_frame(4, 100, 1'b0, 0);
    exp_frames++;
    n_cmp++; if (o_cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_err_clear: got %b expected 0", o_cfg_err); end
    n_cmp++; if (n_cmd !== 1 || n_data !== 4 || n_done !== 1) begin n_bad++; $display("FAIL cfg_frame: got cmd=%0d data=%0d done=%0d expected 1/4/1", n_cmd, n_data, n_done); end
  endtask

  task automatic test_enable_drop();
    int cmds;
    int busy;
    cmds = 0; busy = 0;
    i_width = 16'd2; i_height = 16'd2; i_tft_rdy = 1'b1; i_enable = 1'b1;
    run_frame(4, 200, 1'b0, 2);
    exp_frames++;
    n_cmp++; if (n_data !== 4 || n_done !== 1 || done_cnt !== 32'(exp_frames)) begin n_bad++; $display("FAIL drop_frame: got data=%0d done=%0d count=%0d expected 4/1/%0d", n_data, n_done, done_cnt, exp_frames); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL drop_data[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    repeat (6) begin
      tick();
      if (o_cmd_stb) cmds++;
      if (o_frame_busy) busy++;
    end
    n_cmp++; if (cmds !== 0 || busy !== 0) begin n_bad++; $display("FAIL drop_stays_idle: got cmd=%0d busy=%0d expected 0/0", cmds, busy); end
  endtask

  task automatic test_reset_mid();
    int cmds;
    cmds = 0;
    i_width = 16'd100; i_height = 16'd1; i_tft_rdy = 1'b1; i_enable = 1'b1;
    present_pixel();
    repeat (10) tick();
    n_cmp++; if (o_frame_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b expected 1", o_frame_busy); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({o_cmd_stb, o_data_stb, o_pixel_stb, o_frame_busy, o_frame_done, o_underrun, o_cfg_err} !== 7'd0) begin n_bad++; $display("FAIL rstmid_async_flags: got %b expected 0", {o_cmd_stb, o_data_stb, o_pixel_stb, o_frame_busy, o_frame_done, o_underrun, o_cfg_err}); end
    n_cmp++; if (o_frame_count !== 32'd0 || o_data !== 24'd0) begin n_bad++; $display("FAIL rstmid_count_data: got count=%0d data=%h expected 0/0", o_frame_count, o_data); end
    i_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      tick();
      if (o_cmd_stb) cmds++;
    end
    n_cmp++; if (cmds !== 0 || o_frame_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got cmd=%0d busy=%b expected 0/0", cmds, o_frame_busy); end
    i_width = 16'd1; i_height = 16'd1; i_enable = 1'b1;
    run_frame(1, 100, 1'b0, 0);
    n_cmp++; if (n_done !== 1 || done_cnt !== 32'd1) begin n_bad++; $display("FAIL rstmid_count_restart: got done=%0d count=%0d expected 1/1", n_done, done_cnt); end
  endtask

  initial begin
    rst = 1'b0; i_enable = 1'b0; i_width = 16'd0; i_height = 16'd0;
    i_fill_color = 24'd0; i_pixel_rdy = 1'b0; i_red = 8'd0; i_green = 8'd0; i_blue = 8'd0;
    i_tft_rdy = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_tft_toggle();
    test_stall();
    test_cfg_err();
    test_enable_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tft_frame_sequencer.md
# tft_frame_sequencer

Frame-level controller between the pixel reader and the TFT command/data writer. It opens each frame with a memory-write command and paces pixel strobes out of the pixel reader. It counts column and row against latched dimensions and closes the frame with a done pulse. If the pixel source stalls too long, it completes the frame with a fill colour so the panel never hangs mid-frame.

## Interface
Parameters:
- `STALL_LIMIT`, 1024: consecutive starved cycles in PIXEL before fill mode engages (≥2).
- `CMD_MEM_WRITE`, 8'h2C: command byte issued at start of frame.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `i_enable`  in  1  level; frames start back-to-back while high.
- `i_width`  in  16  pixels per line; latched at frame start.
- `i_height`  in  16  lines per frame; latched at frame start.
- `i_fill_color`  in  24  {R,G,B} sent in fill mode.
- `i_pixel_rdy`  in  1  pixel reader has a valid pixel.
- `o_pixel_stb`  out  1  one-cycle pixel consume strobe to reader.
- `i_red`, `i_green`, `i_blue`  in  8 each  reader pixel.
- `i_tft_rdy`  in  1  TFT writer can accept a command or data word this cycle.
- `o_cmd_stb`  out  1  one-cycle command strobe.
- `o_cmd_data`  out  8  command byte.
- `o_data_stb`  out  1  one-cycle pixel-data strobe.
- `o_data`  out  24  {R,G,B} pixel data.
- `o_frame_busy`  out  1  high from SOF through EOF.
- `o_frame_done`  out  1  one-cycle pulse at end of frame.
- `o_frame_count`  out  32  completed frames, wraps at 2^32.
- `o_underrun`  out  1  sticky; set on fill-mode entry, cleared at next SOF.
- `o_cfg_err`  out  1  high while enabled with zero width or height.

## Operation
- States: IDLE, SOF, PIXEL, EOF.
- IDLE:
  - If `i_enable` is high and both dimensions are nonzero: latch width/height, clear x, y, stall counter and `o_underrun`, then go to SOF.
  - If `i_enable` is high with a zero dimension: stay in IDLE with `o_cfg_err`=1.
- SOF: wait for `i_tft_rdy`. In that cycle register `o_cmd_stb`=1 and `o_cmd_data`=`CMD_MEM_WRITE`, then go to PIXEL.
- PIXEL (normal):
  - On a cycle with `i_pixel_rdy` && `i_tft_rdy` && !`o_pixel_stb`, next cycle drive `o_pixel_stb`=1 and `o_data_stb`=1 with `o_data`={`i_red`,`i_green`,`i_blue`} sampled in the qualifying cycle.
  - Strobes never occur on consecutive cycles, because the reader needs one cycle to re-present `i_pixel_rdy`.
- PIXEL (fill):
  - The stall counter increments on each PIXEL cycle with `i_pixel_rdy`=0 and resets on any strobe.
  - When it reaches `STALL_LIMIT`, set `o_underrun` and enter fill mode for the rest of the frame.
  - Fill mode: every cycle with `i_tft_rdy` && !`o_data_stb` produces `o_data_stb` with `o_data`=`i_fill_color`. No `o_pixel_stb` is issued.
- Counting, per data strobe:
  - x += 1.
  - When x == width−1: x←0, y += 1.
  - The strobe at x==width−1 and y==height−1 is the last one; go to EOF.
- EOF: for one cycle, `o_frame_done`=1 and `o_frame_count`+1. Return to IDLE.
- `i_enable` falling mid-frame does not abort; the frame completes.
- Changes to `i_width`/`i_height` mid-frame are ignored until the next SOF.
- Counter arithmetic is 16-bit unsigned; width/height up to 65535.

## Timing
- Reset (`rst`=0, async): state IDLE; all outputs 0; `o_frame_count`=0; x, y and stall counter 0.
- IDLE→SOF: 1 cycle after enable is sampled.
- Command strobe: registered, 1 cycle after `i_tft_rdy` is sampled high in SOF.
- Pixel path latency: qualifying cycle → strobe on the next edge. Minimum 2 cycles per pixel.
- `o_data_stb` and `o_pixel_stb` are coincident in normal mode.
- Last data strobe → `o_frame_done` on the following cycle. `o_frame_busy` drops in that same cycle.
- Back-to-back frames: SOF of the next frame occurs 2 cycles after `o_frame_done` when `i_enable` is held.
- `i_tft_rdy` low blocks all new strobes; the counters hold.

## Test plan
- Reset mid-PIXEL, with `rst` low for 3 cycles → all outputs 0 immediately (async), state IDLE, `o_frame_count`=0.
- Width=4, height=2, reader always ready, `i_tft_rdy`=1 → one `o_cmd_stb` with 8'h2C, then exactly 8 paired pixel/data strobes spaced 2 cycles apart, then `o_frame_done` once and `o_frame_count`=1.
- Width=3, height=1, `i_tft_rdy` toggling 1/0 every cycle → 3 data strobes, each only after a ready cycle, and data equal to the sampled pixels.
- `STALL_LIMIT`=8, width=4, height=1, reader supplies 1 pixel then stalls → after 8 starved cycles `o_underrun`=1, then 3 strobes of `i_fill_color`=24'h123456 with no `o_pixel_stb`, then done. The next SOF clears `o_underrun`.
- Width=0 with enable high → no `o_cmd_stb`, `o_cfg_err`=1. Setting width to 2 then clears `o_cfg_err` and starts a frame.
- Enable dropped after the 2nd pixel of a 2×2 frame, with width changed to 9 → frame completes with 4 strobes, then state stays IDLE.
